// File: rtl/man_pkg.sv
// Shared types and helpers for the Manchester frame transmitter.
package man_pkg;

   localparam int unsigned SYNC_HALVES = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_DATA,
      S_PARITY,
      S_GAP
   } state_t;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/man_sync_fifo.sv
// Word FIFO with registered level/full/empty and a sticky overflow flag.
module man_sync_fifo
   import man_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                    clk_in,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    rd_en,
   input  logic                    ovf_clr,
   output logic [DATA_W-1:0]       rd_data_c,
   output logic [clog2(DEPTH):0]   level,
   output logic                    full,
   output logic                    empty,
   output logic                    overflow
);

   localparam int unsigned PTR_W = clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [LVL_W-1:0]  r_level;
   logic [LVL_W-1:0]  w_level_nxt;
   logic              r_full;
   logic              r_empty;
   logic              r_ovf;
   logic              w_wr_ok;
   logic              w_rd_ok;

   // A write into a full FIFO is dropped regardless of a same-cycle pop.
   assign w_wr_ok = wr_en & ~r_full;
   assign w_rd_ok = rd_en & ~r_empty;

   always_comb begin
      w_level_nxt = r_level;
      if (w_wr_ok && !w_rd_ok)
         w_level_nxt = r_level + LVL_W'(1);
      else if (!w_wr_ok && w_rd_ok)
         w_level_nxt = r_level - LVL_W'(1);
   end

   always_ff @(posedge clk_in) begin
      if (w_wr_ok)
         r_mem[r_wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_ovf    <= 1'b0;
      end else begin
         if (w_wr_ok)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_rd_ok)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == LVL_W'(DEPTH));
         r_empty <= (w_level_nxt == '0);
         // A dropped write wins over a coincident clear.
         if (wr_en && r_full)
            r_ovf <= 1'b1;
         else if (ovf_clr)
            r_ovf <= 1'b0;
      end
   end

   assign rd_data_c = r_mem[r_rd_ptr];
   assign level     = r_level;
   assign full      = r_full;
   assign empty     = r_empty;
   assign overflow  = r_ovf;

endmodule

// File: rtl/man_coding_tx.sv
// Manchester frame transmitter: FIFO-fed, self-timed sync/data/parity/gap serialiser.
module man_coding_tx
   import man_pkg::*;
#(
   parameter int unsigned DATA_W        = 16,
   parameter int unsigned DEPTH         = 4,
   parameter int unsigned HALF_BIT_CLKS = 18,
   parameter int unsigned PARITY_EN     = 1,
   parameter int unsigned GAP_BITS      = 2,
   parameter int unsigned IDLE_LVL      = 0,
   parameter int unsigned POLARITY      = 0
) (
   input  logic                  clk_in,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  en,
   input  logic                  ovf_clr,
   output logic                  code,
   output logic                  busy,
   output logic                  frame_done,
   output logic [clog2(DEPTH):0] fifo_level,
   output logic                  full,
   output logic                  empty,
   output logic                  overflow
);

   localparam int unsigned TMR_W      = clog2(HALF_BIT_CLKS);
   localparam int unsigned BIT_W      = clog2(DATA_W) + 1;
   localparam int unsigned GAP_HALVES = 2 * GAP_BITS;
   localparam int unsigned HALF_W     =
      clog2((GAP_HALVES > SYNC_HALVES) ? GAP_HALVES : SYNC_HALVES);
   localparam logic L_IDLE  = 1'(IDLE_LVL);
   localparam logic L_POL   = 1'(POLARITY);
   localparam logic HAS_PAR = (PARITY_EN != 0);

   state_t              r_state, w_state_nxt;
   logic [TMR_W-1:0]    r_timer, w_timer_nxt;
   logic [HALF_W-1:0]   r_half, w_half_nxt;
   logic [BIT_W-1:0]    r_bit, w_bit_nxt;
   logic [DATA_W-1:0]   r_shift, w_shift_nxt;
   logic                r_par, w_par_nxt;
   logic                r_code, w_lvl;
   logic                r_busy;
   logic                r_done, w_done_nxt;
   logic                w_tick;
   logic                w_pop;
   logic                w_empty;
   logic [DATA_W-1:0]   w_head;

   man_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk_in    (clk_in),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .rd_en     (w_pop),
      .ovf_clr   (ovf_clr),
      .rd_data_c (w_head),
      .level     (fifo_level),
      .full      (full),
      .empty     (w_empty),
      .overflow  (overflow)
   );

   assign w_tick = (r_timer == TMR_W'(HALF_BIT_CLKS - 1));

   // Next-state, datapath and line-level decode.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = w_tick ? '0 : r_timer + TMR_W'(1);
      w_half_nxt  = r_half;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_par_nxt   = r_par;
      w_done_nxt  = 1'b0;
      w_pop       = 1'b0;
      w_lvl       = L_IDLE;
      case (r_state)
         S_IDLE: begin
            w_timer_nxt = '0;
            if (en && !w_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_head;
               w_par_nxt   = ~^w_head;
               w_half_nxt  = '0;
               w_bit_nxt   = '0;
               w_state_nxt = S_SYNC;
            end
         end
         S_SYNC: begin
            // Three halves opposite idle then three at idle: never a legal bit.
            w_lvl = (r_half < HALF_W'(SYNC_HALVES / 2)) ? ~L_IDLE : L_IDLE;
            if (w_tick) begin
               if (r_half == HALF_W'(SYNC_HALVES - 1)) begin
                  w_half_nxt  = '0;
                  w_state_nxt = S_DATA;
               end else begin
                  w_half_nxt = r_half + HALF_W'(1);
               end
            end
         end
         S_DATA: begin
            w_lvl = r_shift[DATA_W-1] ^ r_half[0] ^ L_POL;
            if (w_tick) begin
               if (r_half[0] == 1'b0) begin
                  w_half_nxt = HALF_W'(1);
               end else begin
                  w_half_nxt  = '0;
                  w_shift_nxt = r_shift << 1;
                  if (r_bit == BIT_W'(DATA_W - 1)) begin
                     w_bit_nxt = '0;
                     if (HAS_PAR) begin
                        w_state_nxt = S_PARITY;
                     end else begin
                        w_state_nxt = S_GAP;
                        w_done_nxt  = 1'b1;
                     end
                  end else begin
                     w_bit_nxt = r_bit + BIT_W'(1);
                  end
               end
            end
         end
         S_PARITY: begin
            w_lvl = r_par ^ r_half[0] ^ L_POL;
            if (w_tick) begin
               if (r_half[0] == 1'b0) begin
                  w_half_nxt = HALF_W'(1);
               end else begin
                  w_half_nxt  = '0;
                  w_state_nxt = S_GAP;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         S_GAP: begin
            if (w_tick) begin
               if (r_half == HALF_W'(GAP_HALVES - 1)) begin
                  w_half_nxt  = '0;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_half_nxt = r_half + HALF_W'(1);
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_timer <= '0;
         r_half  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_code  <= L_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_half  <= w_half_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_par   <= w_par_nxt;
         r_code  <= w_lvl;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_done  <= w_done_nxt;
      end
   end

   assign code       = r_code;
   assign busy       = r_busy;
   assign frame_done = r_done;
   assign empty      = w_empty;

endmodule
